// File: rtl/acl_pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package acl_pll_sup_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        READY     = 3'd3,
        FAILED    = 3'd4
    } state_t;

    // Bits needed to hold values 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/acl_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit; resets to 0.
module acl_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    // Shift the async input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/acl_pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, retries timeouts, sticky fail.
module acl_pll_lock_supervisor
    import acl_pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                              refclk,
    input  logic                              rst,
    input  logic                              locked,
    input  logic                              force_relock,
    output logic                              pll_rst,
    output logic                              pll_ready,
    output logic                              lock_lost,
    output logic                              fail,
    output logic [cnt_width(MAX_RETRIES)-1:0] retry_count,
    output logic [STATE_W-1:0]                state_dbg
);

    localparam int CNT_TOP =
        (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES)
            ? ((RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES)
            : ((LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES);
    localparam int CNT_W = cnt_width(CNT_TOP);
    localparam int RC_W  = cnt_width(MAX_RETRIES);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = '1;
    localparam logic [RC_W-1:0]  RC_MAX       = RC_W'(MAX_RETRIES);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              locked_s;

    acl_sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (locked),
        .q  (locked_s)
    );

    // Saturating increment shared by all timed states.
    always_comb begin
        cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    end

    // Supervisor FSM with registered outputs; force_relock overrides every state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            pll_ready   <= 1'b0;
            lock_lost   <= 1'b0;
            fail        <= 1'b0;
        end else begin
            lock_lost <= 1'b0;
            if (force_relock) begin
                state       <= RESET_PLL;
                cnt         <= '0;
                retry_count <= '0;
                fail        <= 1'b0;
                pll_rst     <= 1'b1;
                pll_ready   <= 1'b0;
            end else begin
                case (state)
                    RESET_PLL: begin
                        if (cnt == PULSE_LAST) begin
                            state   <= WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    WAIT_LOCK: begin
                        if (locked_s) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            cnt <= '0;
                            if (retry_count < RC_MAX) begin
                                retry_count <= retry_count + 1'b1;
                                state       <= RESET_PLL;
                                pll_rst     <= 1'b1;
                            end else begin
                                state <= FAILED;
                                fail  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    STABLE: begin
                        if (!locked_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state       <= READY;
                            cnt         <= '0;
                            pll_ready   <= 1'b1;
                            retry_count <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    READY: begin
                        retry_count <= '0;
                        if (!locked_s) begin
                            state     <= RESET_PLL;
                            cnt       <= '0;
                            pll_ready <= 1'b0;
                            lock_lost <= 1'b1;
                            pll_rst   <= 1'b1;
                        end
                    end
                    FAILED: begin
                        fail      <= 1'b1;
                        pll_rst   <= 1'b0;
                        pll_ready <= 1'b0;
                    end
                    default: begin
                        state   <= RESET_PLL;
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_acl_pll_lock_supervisor.sv
// Directed bench for acl_pll_lock_supervisor with small timing parameters.
module tb_acl_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic       pll_ready;
    logic       lock_lost;
    logic       fail;
    logic [1:0] retry_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       lk;
        logic       fr;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    acl_pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2),
        .SYNC_STAGES        (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .pll_ready   (pll_ready),
        .lock_lost   (lock_lost),
        .fail        (fail),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    always #5 refclk = ~refclk;

    // Expected output word: {pll_rst, pll_ready, lock_lost, fail, retry_count, state_dbg}.
    function automatic logic [9:0] ex(bit r, bit rdy, bit ll, bit f, int rc, int st);
        return {r, rdy, ll, f, 2'(rc), 3'(st)};
    endfunction

    task automatic add(bit lk, bit fr, logic [9:0] e);
        vec_t v;
        v.lk  = lk;
        v.fr  = fr;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic add_n(int n, bit lk, logic [9:0] e);
        for (int i = 0; i < n; i++) add(lk, 1'b0, e);
    endtask

    task automatic chk(string name, logic [9:0] e);
        logic [9:0] got;
        got = {pll_rst, pll_ready, lock_lost, fail, retry_count, state_dbg};
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s: got rst/rdy/ll/fail/rc/st=%b exp=%b at %0t", name, got, e, $time);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    initial begin
        // Scenario 1: bring-up, locked raised after 5th edge, ready 11 edges later.
        add_n(3, 1'b0, ex(1, 0, 0, 0, 0, 0));
        add_n(2, 1'b0, ex(0, 0, 0, 0, 0, 1));
        add_n(2, 1'b1, ex(0, 0, 0, 0, 0, 1));
        add_n(8, 1'b1, ex(0, 0, 0, 0, 0, 2));
        add_n(2, 1'b1, ex(0, 1, 0, 0, 0, 3));
        // Scenario 4: lock drop in READY.
        add_n(2, 1'b0, ex(0, 1, 0, 0, 0, 3));
        add_n(1, 1'b0, ex(1, 0, 1, 0, 0, 0));
        add_n(3, 1'b0, ex(1, 0, 0, 0, 0, 0));
        add_n(1, 1'b0, ex(0, 0, 0, 0, 0, 1));
        // Scenario 2: one-cycle glitch during qualification.
        add_n(2, 1'b1, ex(0, 0, 0, 0, 0, 1));
        add_n(6, 1'b1, ex(0, 0, 0, 0, 0, 2));
        add_n(1, 1'b0, ex(0, 0, 0, 0, 0, 2));
        add_n(1, 1'b1, ex(0, 0, 0, 0, 0, 2));
        add_n(1, 1'b1, ex(0, 0, 0, 0, 0, 1));
        add_n(8, 1'b1, ex(0, 0, 0, 0, 0, 2));
        add_n(1, 1'b1, ex(0, 1, 0, 0, 0, 3));

        // Reset state while rst held.
        repeat (2) @(posedge refclk);
        #1;
        chk("reset_state", ex(1, 0, 0, 0, 0, 0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            locked       = vecs[i].lk;
            force_relock = vecs[i].fr;
            step();
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // force_relock coincident with lock drop seen in READY: no lock_lost.
        locked = 1'b0;
        step(); chk("fr_ready_a", ex(0, 1, 0, 0, 0, 3));
        step(); chk("fr_ready_b", ex(0, 1, 0, 0, 0, 3));
        force_relock = 1'b1;
        step(); chk("fr_coincide", ex(1, 0, 0, 0, 0, 0));
        force_relock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("fr_pulse", ex(1, 0, 0, 0, 0, 0));
        end
        step(); chk("fr_wait", ex(0, 0, 0, 0, 0, 1));

        // Scenario 3: timeouts, two retries, then sticky fail.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 19; k++) begin
                step(); chk($sformatf("to_wait%0d", r), ex(0, 0, 0, 0, r, 1));
            end
            step();
            if (r < 2) begin
                chk($sformatf("to_retry%0d", r), ex(1, 0, 0, 0, r + 1, 0));
                for (int k = 0; k < 3; k++) begin
                    step(); chk($sformatf("to_pulse%0d", r), ex(1, 0, 0, 0, r + 1, 0));
                end
                step(); chk($sformatf("to_end%0d", r), ex(0, 0, 0, 0, r + 1, 1));
            end else begin
                chk("to_failed", ex(0, 0, 0, 1, 2, 4));
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(); chk("failed_sticky", ex(0, 0, 0, 1, 2, 4));
        end

        // Scenario 5: recover from FAILED with force_relock, nominal lock.
        force_relock = 1'b1;
        step(); chk("relock_force", ex(1, 0, 0, 0, 0, 0));
        force_relock = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); chk("relock_pulse", ex(1, 0, 0, 0, 0, 0));
        end
        step(); chk("relock_wait", ex(0, 0, 0, 0, 0, 1));
        locked = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(); chk($sformatf("relock_q%0d", k), ex(0, 0, 0, 0, 0, (k < 3) ? 1 : 2));
        end
        step(); chk("relock_ready", ex(0, 1, 0, 0, 0, 3));

        // Scenario 6: async reset in the middle of WAIT_LOCK.
        locked       = 1'b0;
        force_relock = 1'b1;
        step(); chk("ar_force", ex(1, 0, 0, 0, 0, 0));
        force_relock = 1'b0;
        repeat (4) step();
        repeat (3) step();
        chk("ar_wait", ex(0, 0, 0, 0, 0, 1));
        #2 rst = 1'b1;
        #1 chk("ar_async", ex(1, 0, 0, 0, 0, 0));
        @(posedge refclk);
        #1 rst = 1'b0;
        step(); chk("ar_after", ex(1, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
